// File: rtl/collision_detect.sv
// Goose/bean collision detector and game-state tracker, evaluated once per scanned frame.
// Optional build macro GOOSE_GODMODE_EN: collisions still pulse hit and enter HIT but never cost lives.
module collision_detect #(
    parameter int H_ACTIVE      = 640,
    parameter int V_ACTIVE      = 480,
    parameter int LIVES         = 3,
    parameter int INVULN_FRAMES = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        pix_en,
    input  logic        goose,
    input  logic        bean,
    input  logic        start,
    output logic        hit,
    output logic        freeze,
    output logic        game_over,
    output logic [1:0]  state,
    output logic [1:0]  lives,
    output logic [15:0] score
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HIT  = 2'd2,
        OVER = 2'd3
    } state_t;

    localparam logic [9:0] H_LAST     = 10'(H_ACTIVE - 1);
    localparam logic [9:0] V_LAST     = 10'(V_ACTIVE - 1);
    localparam logic [1:0] LIVES_INIT = 2'(LIVES);
    localparam logic [7:0] GRACE_INIT = 8'(INVULN_FRAMES);

    state_t      st, st_nx;
    logic [1:0]  lives_nx;
    logic [15:0] score_nx, score_inc;
    logic [7:0]  grace, grace_nx;
    logic        ov;
    logic        hit_nx;
    logic        frame_end;
    logic        pix_overlap;
    logic        ov_frame;

    assign frame_end   = pix_en && (x == H_LAST) && (y == V_LAST);
    assign pix_overlap = pix_en && goose && bean && (x <= H_LAST) && (y <= V_LAST);
    // The frame_end pixel itself still counts for the frame that is ending.
    assign ov_frame    = ov | pix_overlap;
    assign score_inc   = (score == 16'hFFFF) ? score : score + 16'd1;

    always_comb begin
        st_nx    = st;
        lives_nx = lives;
        score_nx = score;
        grace_nx = grace;
        hit_nx   = 1'b0;
        if (frame_end) begin
            case (st)
                IDLE, OVER: begin
                    if (start) begin
                        st_nx    = RUN;
                        lives_nx = LIVES_INIT;
                        score_nx = 16'd0;
                    end
                end
                RUN: begin
                    if (ov_frame) begin
                        hit_nx   = 1'b1;
                        grace_nx = GRACE_INIT;
                        st_nx    = HIT;
`ifndef GOOSE_GODMODE_EN
                        if (lives != 2'd0)
                            lives_nx = lives - 2'd1;
                        if (lives <= 2'd1)
                            st_nx = OVER;
`endif
                    end else begin
                        score_nx = score_inc;
                    end
                end
                HIT: begin
                    score_nx = score_inc;
                    grace_nx = (grace != 8'd0) ? grace - 8'd1 : 8'd0;
                    if (grace <= 8'd1)
                        st_nx = RUN;
                end
                default: st_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st    <= IDLE;
            lives <= LIVES_INIT;
            score <= 16'd0;
            grace <= 8'd0;
            ov    <= 1'b0;
            hit   <= 1'b0;
        end else begin
            st    <= st_nx;
            lives <= lives_nx;
            score <= score_nx;
            grace <= grace_nx;
            ov    <= frame_end ? 1'b0 : ov_frame;
            hit   <= hit_nx;
        end
    end

    assign state     = st;
    assign freeze    = (st == IDLE) || (st == OVER);
    assign game_over = (st == OVER);

endmodule

// File: tb/tb_collision_detect.sv
// Scoreboard bench: a per-frame game model predicts the outputs after every frame_end/reset cycle.
module tb_collision_detect;

    localparam int H   = 8;
    localparam int V   = 4;
    localparam int L   = 3;
    localparam int INV = 4;
    localparam int FE_IDX = (V - 1) * (H + 2) + (H - 1);

    logic        clk = 1'b0;
    logic        reset, pix_en, goose, bean, start;
    logic [9:0]  x, y;
    logic        hit, freeze, game_over;
    logic [1:0]  state, lives;
    logic [15:0] score;

    collision_detect #(.H_ACTIVE(H), .V_ACTIVE(V), .LIVES(L), .INVULN_FRAMES(INV)) dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .pix_en(pix_en), .goose(goose),
        .bean(bean), .start(start), .hit(hit), .freeze(freeze), .game_over(game_over),
        .state(state), .lives(lives), .score(score)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit hit; bit freeze; bit over; int st; int lives; int score;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Model of the game: 0 idle, 1 run, 2 hit/grace, 3 over.
    int m_st, m_lives, m_score, m_grace;
    bit m_acc;

    task automatic push_exp(bit h);
        exp_t e;
        e.hit = h; e.st = m_st; e.lives = m_lives; e.score = m_score;
        e.freeze = (m_st == 0 || m_st == 3);
        e.over = (m_st == 3);
        exp_q.push_back(e);
    endtask

    task automatic step();
        bit fe, cur, ovf, h;
        fe  = pix_en && x == 10'(H - 1) && y == 10'(V - 1);
        cur = pix_en && goose && bean && int'(x) < H && int'(y) < V;
        h = 0;
        if (reset) begin
            m_st = 0; m_lives = L; m_score = 0; m_grace = 0; m_acc = 0;
            push_exp(0);
        end else if (fe) begin
            ovf = m_acc | cur;
            m_acc = 0;
            if (m_st == 0 || m_st == 3) begin
                if (start) begin m_st = 1; m_lives = L; m_score = 0; end
            end else if (m_st == 1) begin
                if (ovf) begin
                    h = 1; m_st = 2; m_grace = INV;
`ifndef GOOSE_GODMODE_EN
                    m_lives = m_lives - 1;
                    if (m_lives == 0) m_st = 3;
`endif
                end else if (m_score < 65535) m_score++;
            end else begin
                if (m_score < 65535) m_score++;
                m_grace--;
                if (m_grace == 0) m_st = 1;
            end
            push_exp(h);
        end else begin
            m_acc |= cur;
        end
        @(posedge clk);
        #1;
    endtask

    // kind: 0 clean, 1 overlap at a random active pixel, 2 only at last active pixel,
    // 3 only just right of the active area, 4 only at (0,0).
    // smode: 0 start low, 1 start only at frame_end, 2 start everywhere but frame_end, 3 random.
    task automatic frame(int kind, int smode, int rst_at);
        int ox, oy;
        ox = $urandom_range(0, H - 1);
        oy = $urandom_range(0, V - 1);
        for (int yy = 0; yy < V + 2; yy++) begin
            for (int xx = 0; xx < H + 2; xx++) begin
                int idx;
                bit act, isfe;
                idx  = yy * (H + 2) + xx;
                act  = xx < H && yy < V;
                isfe = idx == FE_IDX;
                if ($urandom_range(0, 7) == 0) begin
                    pix_en = 0; goose = 1; bean = 1; reset = 0;
                    x = 10'($urandom_range(0, 1023));
                    y = 10'($urandom_range(0, 1023));
                    start = 1'($urandom);
                    step();
                end
                pix_en = 1;
                x = 10'(xx);
                y = 10'(yy);
                reset = (idx == rst_at);
                goose = 1'($urandom);
                bean  = 1'($urandom);
                if (act || kind >= 2) bean = bean & ~goose;
                if ((kind == 1 && xx == ox && yy == oy) || (kind == 2 && isfe) ||
                    (kind == 3 && xx == H && yy == 1) || (kind == 4 && idx == 0)) begin
                    goose = 1; bean = 1;
                end
                case (smode)
                    0: start = 0;
                    1: start = isfe;
                    2: start = !isfe;
                    default: start = 1'($urandom);
                endcase
                step();
            end
        end
        reset = 0;
        pix_en = 0;
    endtask

    logic probe = 1'b0;
    always @(posedge clk)
        probe <= reset || (pix_en && x == 10'(H - 1) && y == 10'(V - 1));

    always @(negedge clk) begin
        if (probe) begin
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard_empty: DUT output with no expectation queued");
                miscompares++;
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                vectors++;
                if (hit !== e.hit || freeze !== e.freeze || game_over !== e.over ||
                    int'(state) != e.st || int'(lives) != e.lives || int'(score) != e.score ||
                    $isunknown({hit, freeze, game_over, state, lives, score})) begin
                    $display("FAIL frame_result #%0d: got hit=%b frz=%b over=%b st=%0d lives=%0d score=%0d, want hit=%b frz=%b over=%b st=%0d lives=%0d score=%0d",
                             vectors, hit, freeze, game_over, state, lives, score,
                             e.hit, e.freeze, e.over, e.st, e.lives, e.score);
                    miscompares++;
                end
            end
        end else if (hit !== 1'b0) begin
            $display("FAIL stray_hit: hit=%b outside post-frame_end cycle, want 0", hit);
            miscompares++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1; pix_en = 0; goose = 0; bean = 0; start = 0; x = 0; y = 0;
        step(); step();
        reset = 0;
        step();
        frame(0, 2, -1);                  // start away from frame_end: stays idle
        frame(0, 1, -1);                  // enter RUN
        frame(0, 0, -1);                  // score 1
        frame(1, 0, -1);                  // hit, lives 2
        repeat (INV) frame(1, 0, -1);     // grace: overlaps ignored
        frame(1, 0, -1);                  // hit, lives 1
        repeat (INV) frame(0, 0, -1);
        frame(3, 0, -1);                  // outside-area overlap ignored
        frame(2, 0, -1);                  // last-pixel overlap: third hit
        frame(3, 2, -1);
        frame(0, 1, -1);                  // restart
        frame(2, 0, -1);
        frame(0, 0, -1);
        repeat (INV) frame(0, 0, -1);
        frame(4, 0, 5);                   // reset mid-frame discards earlier overlap
        frame(0, 1, -1);
        frame(0, 0, -1);
        frame(4, 0, FE_IDX);              // reset beats simultaneous frame_end
        frame(0, 1, -1);
        for (int i = 0; i < 10; i++) begin
            frame(1, 0, -1);
            repeat (INV) frame(0, 0, -1);
        end
        frame(0, 1, -1);
        for (int i = 0; i < 150; i++)
            frame($urandom_range(0, 4), $urandom_range(0, 3),
                  ($urandom_range(0, 19) == 0) ? $urandom_range(0, FE_IDX + 3) : -1);
        repeat (3) step();
        if (exp_q.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/collision_detect.md
COLLISION_DETECT -- requirements
Module: collision_detect

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 SHALL have parameter LIVES, default 3, lives loaded at game start (range 1-3).
REQ-004 SHALL have parameter INVULN_FRAMES, default 60, post-hit grace period in frames (range 1-255).
REQ-005 SHALL have ports as follows; one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  system clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 x  in  10  current scan pixel column.
REQ-009 y  in  10  current scan pixel row.
REQ-010 pix_en  in  1  x/y valid this cycle; one pulse per scanned pixel.
REQ-011 goose  in  1  goose sprite covers (x,y).
REQ-012 bean  in  1  bean obstacle covers (x,y).
REQ-013 start  in  1  level-sampled start/restart request.
REQ-014 hit  out  1  one-cycle pulse: collision accepted.
REQ-015 freeze  out  1  movers SHALL hold position while high.
REQ-016 game_over  out  1  high in OVER state.
REQ-017 state  out  2  IDLE=0, RUN=1, HIT=2, OVER=3.
REQ-018 lives  out  2  remaining lives.
REQ-019 score  out  16  frames survived, unsigned.

Function
REQ-020 Overlap latch SHALL set on any cycle with pix_en=1, goose=1, bean=1, x<H_ACTIVE, y<V_ACTIVE; pixels outside the active area SHALL be ignored.
REQ-021 frame_end SHALL be a single-cycle event on pix_en=1 with x=H_ACTIVE-1 and y=V_ACTIVE-1.
REQ-022 At frame_end the overlap latch SHALL be evaluated including the frame_end pixel itself, then cleared the next cycle; overlap at frame_end counts for the ending frame.
REQ-023 IDLE: freeze=1; start=1 at frame_end -> RUN, lives<=LIVES, score<=0.
REQ-024 RUN: freeze=0; each frame_end without overlap increments score, saturating at 16'hFFFF.
REQ-025 RUN, frame_end with overlap: hit=1 for that one cycle, lives decrements; result lives=0 -> OVER, else -> HIT with grace counter<=INVULN_FRAMES; score not incremented that frame.
REQ-026 HIT: freeze=0; overlaps ignored, no hit; score increments per frame_end; counter decrements per frame_end; transition to RUN at frame_end where counter reaches 0 (exactly INVULN_FRAMES frames).
REQ-027 OVER: freeze=1, game_over=1; score and lives held; start=1 at frame_end -> RUN, lives<=LIVES, score<=0.
REQ-028 All state changes SHALL occur only on frame_end cycles; start outside frame_end SHALL have no effect.
REQ-029 hit SHALL be registered: asserted the cycle after the frame_end input cycle.
REQ-030 lives SHALL never underflow below 0.

Reset
REQ-031 On reset=1: state=IDLE, hit=0, freeze=1, game_over=0, lives=LIVES, score=0, overlap latch=0, grace counter=0.
REQ-032 Reset mid-frame or mid-HIT SHALL discard partial overlap and grace count; reset SHALL override simultaneous frame_end.

Configuration
REQ-033 Macro GOOSE_GODMODE_EN: when defined, accepted collisions still pulse hit and enter HIT, but lives SHALL NOT decrement and OVER SHALL be unreachable; when undefined, REQ-025 applies unchanged.

Verification
REQ-034 Reset, start=1, one clean frame -> state=RUN after first frame_end, score=1 after second frame_end, hit never high.
REQ-035 goose=bean=1 at (100,200) in RUN -> hit one cycle after frame_end, lives 3->2, state=HIT, score unchanged.
REQ-036 Overlap every frame during HIT -> no hit for 60 frames, state=RUN after 60th frame_end, next overlap -> hit, lives=1.
REQ-037 Overlap only at (639,479) and separately only at (640,10) -> first yields hit, second ignored.
REQ-038 Three accepted hits from LIVES=3 -> lives=0, state=OVER, game_over=1, freeze=1; start at frame_end -> RUN, lives=3, score=0.
REQ-039 With GOOSE_GODMODE_EN defined, ten accepted hits -> ten hit pulses, lives stays 3, state never OVER.
